// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM controller.
// Optional feature macro: SRAM_READ_BUFFER_EN (see sram_controller).
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_t;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 1;
  localparam int unsigned ADDR_BASE_DEFAULT   = 1024;
  localparam int unsigned WORD_IDX_W          = 17;

  // Word index relative to the mapped base, wrapping modulo 2^17.
  function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] addr,
                                                        input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return diff[WORD_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry read buffer (valid, 17-bit word tag, 32-bit data).
// Only compiled when SRAM_READ_BUFFER_EN is defined.
`ifdef SRAM_READ_BUFFER_EN
module sram_read_buffer
  import sram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_IDX_W-1:0] lookup_word,
  output logic                  hit,
  output logic [31:0]           data,
  input  logic                  fill_en,
  input  logic                  upd_en,
  input  logic [WORD_IDX_W-1:0] fill_word,
  input  logic [31:0]           fill_data
);

  logic                  valid_q;
  logic [WORD_IDX_W-1:0] tag_q;
  logic [31:0]           data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_word;
      data_q  <= fill_data;
    end else if (upd_en && valid_q && (tag_q == fill_word)) begin
      // Keep the buffered copy coherent with stores to the same word.
      data_q <= fill_data;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_word);
  assign data = data_q;

endmodule
`endif

// File: rtl/sram_controller.sv
// 32-bit MEM-stage access over a 16-bit async SRAM in two half-word phases.
// Define SRAM_READ_BUFFER_EN to add a one-entry read buffer (sram_read_buffer).
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES);

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic                  is_write_q;
  logic [WORD_IDX_W-1:0] word_q;
  logic [31:0]           wdata_q;
  logic [15:0]           low_half_q;
  logic [31:0]           rdata_q;

  logic                  req;
  logic [WORD_IDX_W-1:0] req_word;
  logic                  phase_last;
  logic                  in_phase;
  logic                  buf_hit;
  logic [31:0]           buf_data;
  logic                  hit_now;

  assign req        = wr_en | rd_en;
  assign req_word   = word_index(address, 32'(ADDR_BASE));
  assign phase_last = (cnt_q == LastCnt);
  assign in_phase   = (state_q == StLow) || (state_q == StHigh);
  // A simultaneous write wins, so only a pure read may be served from the buffer.
  assign hit_now    = (state_q == StIdle) && rd_en && !wr_en && buf_hit;

`ifdef SRAM_READ_BUFFER_EN
  logic        fill_en;
  logic        upd_en;
  logic [31:0] fill_data;

  assign fill_en   = (state_q == StHigh) && phase_last && !is_write_q;
  assign upd_en    = (state_q == StHigh) && phase_last && is_write_q;
  assign fill_data = is_write_q ? wdata_q : {SRAM_DQ, low_half_q};

  sram_read_buffer u_read_buffer (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (req_word),
    .hit         (buf_hit),
    .data        (buf_data),
    .fill_en     (fill_en),
    .upd_en      (upd_en),
    .fill_word   (word_q),
    .fill_data   (fill_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      low_half_q <= '0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (hit_now) begin
            rdata_q <= buf_data;
          end else if (req) begin
            // Latch the request so a mid-access deassert cannot disturb it.
            state_q    <= StLow;
            is_write_q <= wr_en;
            word_q     <= req_word;
            wdata_q    <= write_data;
          end
        end
        StLow: begin
          if (phase_last) begin
            if (!is_write_q) low_half_q <= SRAM_DQ;
            state_q <= StHigh;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StHigh: begin
          if (phase_last) begin
            if (!is_write_q) rdata_q <= {SRAM_DQ, low_half_q};
            state_q <= StDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready     = (state_q == StDone) || ((state_q == StIdle) && (!req || hit_now));
  assign read_data = hit_now ? buf_data : rdata_q;

  assign SRAM_ADDR = {word_q, state_q == StHigh};
  assign SRAM_WE_N = !(in_phase && is_write_q);
  assign SRAM_OE_N = !(in_phase && !is_write_q);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = (in_phase && is_write_q)
                   ? ((state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0])
                   : 16'hzzzz;

endmodule
